// File: rtl/comp_pkg.sv
// comp_pkg: shared types and helpers for the pipelined minimum-select tree.
//   DATA_W_DEF - default lane value width.
//   lane_t     - one candidate: value, lane index, beat number and present flag.
//   SENTINEL   - all-ones value carried by masked lanes.
//   merge()    - two-way minimum used by the tree nodes and the burst accumulator.
// The lane_t fields are sized for the widest supported configuration:
// DATA_W <= 32, log2(N_IN) <= 8, BEAT_W <= 16. Narrower users zero-extend.
package comp_pkg;

  localparam int unsigned DATA_W_DEF = 19;

  localparam int unsigned VAL_W      = 32;
  localparam int unsigned IDX_MAX_W  = 8;
  localparam int unsigned BEAT_MAX_W = 16;

  localparam logic [VAL_W-1:0] SENTINEL = '1;

  typedef struct packed {
    logic [VAL_W-1:0]      value;
    logic [IDX_MAX_W-1:0]  idx;
    logic [BEAT_MAX_W-1:0] beat;
    logic                  present;
  } lane_t;

  // b replaces a only when strictly smaller, so ties keep a (lower lane / earlier beat).
  function automatic lane_t merge(lane_t a, lane_t b);
    lane_t r;
    r         = (b.present && (!a.present || (b.value < a.value))) ? b : a;
    r.present = a.present | b.present;
    return r;
  endfunction

endpackage

// File: rtl/comp_node.sv
// comp_node: one registered two-input minimum compare.
//   clk_i   - clock
//   rst_ni  - synchronous active-low reset
//   en_i    - load enable; holds the result when low (pipeline stall)
//   left_i  - lower-lane candidate (wins ties)
//   right_i - higher-lane candidate
//   res_o   - registered merge of the two
module comp_node
  import comp_pkg::*;
(
  input  logic  clk_i,
  input  logic  rst_ni,
  input  logic  en_i,
  input  lane_t left_i,
  input  lane_t right_i,
  output lane_t res_o
);

  lane_t res_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      res_q <= '0;
    end else if (en_i) begin
      res_q <= merge(left_i, right_i);
    end
  end

  assign res_o = res_q;

endmodule

// File: rtl/comp_tree_pipe.sv
// comp_tree_pipe: pipelined N_IN-lane minimum selector with lane masking and an
// optional running minimum across a multi-beat burst.
//   clk, rst_n           - clock, synchronous active-low reset
//   in_valid/in_ready    - input handshake
//   in_data              - lane i at [i*DATA_W +: DATA_W]
//   in_mask              - 1 = lane participates
//   in_mode              - 0 = per-beat result, 1 = accumulate until in_last
//   in_last              - closes an accumulate burst
//   out_valid/out_ready  - output handshake
//   out_data, out_idx    - minimum value and its lane
//   out_beat             - beat of the minimum within the burst (0 in per-beat mode)
//   out_none             - no lane was present in any contributing beat
// One tree level per stage plus a final result/accumulate stage: latency log2(N_IN)+1.
// The whole pipe advances together whenever the output register is free or drained.
module comp_tree_pipe
  import comp_pkg::*;
#(
  parameter  int unsigned DATA_W = DATA_W_DEF,
  parameter  int unsigned N_IN   = 4,
  parameter  int unsigned BEAT_W = 8,
  localparam int unsigned LVL    = $clog2(N_IN),
  localparam int unsigned IDX_W  = LVL
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N_IN*DATA_W-1:0] in_data,
  input  logic [N_IN-1:0]        in_mask,
  input  logic                   in_mode,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      out_data,
  output logic [IDX_W-1:0]       out_idx,
  output logic [BEAT_W-1:0]      out_beat,
  output logic                   out_none
);

  localparam lane_t ACC_CLR = '{value: SENTINEL, idx: '0, beat: '0, present: 1'b0};

  logic adv;
  logic out_valid_q;

  assign adv      = !out_valid_q || out_ready;
  assign in_ready = adv;

  // Heap-ordered tree: node k merges children 2k (lower lanes) and 2k+1.
  // Leaves N_IN..2*N_IN-1 are the preprocessed input lanes, node 1 is the root.
  lane_t tree [1:2*N_IN-1];

  for (genvar i = 0; i < N_IN; i++) begin : g_leaf
    assign tree[N_IN+i] = '{
      value:   in_mask[i] ? VAL_W'(in_data[i*DATA_W +: DATA_W]) : SENTINEL,
      idx:     IDX_MAX_W'(i),
      beat:    '0,
      present: in_mask[i]
    };
  end

  for (genvar k = 1; k < N_IN; k++) begin : g_node
    comp_node u_node (
      .clk_i   (clk),
      .rst_ni  (rst_n),
      .en_i    (adv),
      .left_i  (tree[2*k]),
      .right_i (tree[2*k+1]),
      .res_o   (tree[k])
    );
  end

  // Per-level sideband bits travelling with the tree data.
  logic [LVL:1] vld_q, mode_q, last_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q  <= '0;
      mode_q <= '0;
      last_q <= '0;
    end else if (adv) begin
      vld_q[1]  <= in_valid;
      mode_q[1] <= in_mode;
      last_q[1] <= in_last;
      for (int l = 2; l <= LVL; l++) begin
        vld_q[l]  <= vld_q[l-1];
        mode_q[l] <= mode_q[l-1];
        last_q[l] <= last_q[l-1];
      end
    end
  end

  // Final stage: per-beat result or burst accumulation.
  lane_t             acc_q, acc_d;
  logic [BEAT_W-1:0] cnt_q, cnt_d;
  lane_t             root, merged, res;
  logic              ov_d;

  always_comb begin
    root      = tree[1];
    root.beat = BEAT_MAX_W'(cnt_q);
    merged    = merge(acc_q, root);

    acc_d    = acc_q;
    cnt_d    = cnt_q;
    ov_d     = 1'b0;
    res      = tree[1];
    res.beat = '0;

    if (vld_q[LVL]) begin
      if (!mode_q[LVL]) begin
        // Per-beat result; an open burst (if any) is left untouched.
        ov_d = 1'b1;
      end else if (!last_q[LVL]) begin
        acc_d = merged;
        cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + BEAT_W'(1);
      end else begin
        ov_d  = 1'b1;
        res   = merged;
        acc_d = ACC_CLR;
        cnt_d = '0;
      end
    end
  end

  logic [DATA_W-1:0] out_data_q;
  logic [IDX_W-1:0]  out_idx_q;
  logic [BEAT_W-1:0] out_beat_q;
  logic              out_none_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      out_beat_q  <= '0;
      out_none_q  <= 1'b0;
      acc_q       <= ACC_CLR;
      cnt_q       <= '0;
    end else if (adv) begin
      out_valid_q <= ov_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      if (ov_d) begin
        out_data_q <= res.present ? res.value[DATA_W-1:0] : '1;
        out_idx_q  <= res.present ? res.idx[IDX_W-1:0]    : '0;
        out_beat_q <= res.present ? res.beat[BEAT_W-1:0]  : '0;
        out_none_q <= !res.present;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_idx   = out_idx_q;
  assign out_beat  = out_beat_q;
  assign out_none  = out_none_q;

  // Upper field bits exist only for wider configurations.
  logic unused_bits;
  assign unused_bits = ^{res.value, res.idx, res.beat};

endmodule

// File: tb/tb_comp_tree_pipe.sv
// Testbench for comp_tree_pipe (N_IN=4, DATA_W=19, BEAT_W=8).
// Hand-written reset/latency/mid-burst-reset sequences, a table of directed vectors,
// then randomized traffic checked against a scoreboard fed by a burst-level model.
module tb_comp_tree_pipe;

  localparam int unsigned DATA_W = 19;
  localparam int unsigned N_IN   = 4;
  localparam int unsigned BEAT_W = 8;
  localparam int unsigned IDX_W  = 2;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   in_valid;
  logic                   in_ready;
  logic [N_IN*DATA_W-1:0] in_data;
  logic [N_IN-1:0]        in_mask;
  logic                   in_mode;
  logic                   in_last;
  logic                   out_valid;
  logic                   out_ready;
  logic [DATA_W-1:0]      out_data;
  logic [IDX_W-1:0]       out_idx;
  logic [BEAT_W-1:0]      out_beat;
  logic                   out_none;

  comp_tree_pipe #(
    .DATA_W (DATA_W),
    .N_IN   (N_IN),
    .BEAT_W (BEAT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mask   (in_mask),
    .in_mode   (in_mode),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_beat  (out_beat),
    .out_none  (out_none)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [IDX_W-1:0]  idx;
    logic [BEAT_W-1:0] beat;
    logic              none;
  } res_t;

  typedef struct packed {
    logic [N_IN*DATA_W-1:0] data;
    logic [N_IN-1:0]        mask;
    logic                   mode;
    logic                   last;
  } beat_t;

  typedef struct packed {
    beat_t b;
    logic  exp_out;
    res_t  exp;
  } vec_t;

  res_t  exp_q[$];
  beat_t burst_q[$];
  int    n_cmp  = 0;
  int    n_fail = 0;
  logic  mon_en = 1'b0;
  logic  done;
  logic  saw_low;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
    end
  endtask

  function automatic logic [N_IN*DATA_W-1:0] pack4(int unsigned a, int unsigned b,
                                                   int unsigned c, int unsigned d);
    return {DATA_W'(d), DATA_W'(c), DATA_W'(b), DATA_W'(a)};
  endfunction

  function automatic vec_t mkv(logic [N_IN*DATA_W-1:0] d, logic [N_IN-1:0] m, logic mode,
                               logic last, logic eo, int unsigned ed, int unsigned ei,
                               int unsigned eb, logic en);
    vec_t v;
    v.b.data  = d;
    v.b.mask  = m;
    v.b.mode  = mode;
    v.b.last  = last;
    v.exp_out = eo;
    v.exp     = '{data: DATA_W'(ed), idx: IDX_W'(ei), beat: BEAT_W'(eb), none: en};
    return v;
  endfunction

  function automatic logic [DATA_W-1:0] lane_of(beat_t b, int i);
    return b.data[i*DATA_W +: DATA_W];
  endfunction

  // Reference: the result of a group of beats is the first minimum found scanning
  // beats in arrival order and lanes in index order over every unmasked lane.
  task automatic model_accept(input beat_t b);
    beat_t group[$];
    res_t  r;
    logic  found;
    if (b.mode && !b.last) begin
      burst_q.push_back(b);
      return;
    end
    if (b.mode) begin
      group = burst_q;
      burst_q.delete();
    end
    group.push_back(b);
    r     = '{data: '1, idx: '0, beat: '0, none: 1'b1};
    found = 1'b0;
    foreach (group[k]) begin
      for (int i = 0; i < int'(N_IN); i++) begin
        if (group[k].mask[i] && (!found || lane_of(group[k], i) < r.data)) begin
          found  = 1'b1;
          r.data = lane_of(group[k], i);
          r.idx  = IDX_W'(i);
          r.beat = (k >= (2**BEAT_W - 1)) ? BEAT_W'(2**BEAT_W - 1) : BEAT_W'(k);
          r.none = 1'b0;
        end
      end
    end
    exp_q.push_back(r);
  endtask

  // Called shortly after a rising edge; returns 1ns after the accepting edge.
  task automatic send(input beat_t b, output logic ok);
    int waited;
    waited   = 0;
    ok       = 1'b1;
    in_data  = b.data;
    in_mask  = b.mask;
    in_mode  = b.mode;
    in_last  = b.last;
    in_valid = 1'b1;
    while (1'b1) begin
      @(negedge clk);
      if (in_ready) break;
      waited++;
      if (waited > 200) begin
        ok = 1'b0;
        break;
      end
    end
    if (!ok) check("in_ready_timeout", 64'(in_ready), 64'd1);
    else @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic send_model(input beat_t b);
    logic ok;
    send(b, ok);
    if (ok) model_accept(b);
  endtask

  function automatic beat_t rand_beat(logic mode0_only);
    beat_t b;
    for (int i = 0; i < int'(N_IN); i++) begin
      case ($urandom_range(0, 3))
        0, 1:    b.data[i*DATA_W +: DATA_W] = DATA_W'($urandom_range(0, 15));
        2:       b.data[i*DATA_W +: DATA_W] = DATA_W'($urandom);
        default: b.data[i*DATA_W +: DATA_W] = '1;
      endcase
    end
    b.mask = N_IN'($urandom);
    b.mode = mode0_only ? 1'b0 : 1'($urandom_range(0, 1));
    b.last = ($urandom_range(0, 2) == 0);
    return b;
  endfunction

  task automatic drain();
    out_ready = 1'b1;
    for (int c = 0; c < 100 && exp_q.size() != 0; c++) @(posedge clk);
    repeat (5) @(posedge clk);
    check("drain_left", 64'(exp_q.size()), 64'd0);
    #1;
  endtask

  // Output monitor: scoreboard compare on each transfer, hold check while stalled.
  initial begin
    res_t held, cur, e;
    logic stalled;
    stalled = 1'b0;
    held    = '0;
    forever begin
      @(negedge clk);
      cur = '{data: out_data, idx: out_idx, beat: out_beat, none: out_none};
      if (!mon_en || !rst_n) begin
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          check("hold_valid", 64'(out_valid), 64'd1);
          check("hold_fields", 64'(cur), 64'(held));
        end
        stalled = 1'b0;
        if (out_valid) begin
          if (!out_ready) begin
            held    = cur;
            stalled = 1'b1;
          end else if (exp_q.size() == 0) begin
            check("spurious_out", 64'(out_valid), 64'd0);
          end else begin
            e = exp_q.pop_front();
            check("out_data", 64'(out_data), 64'(e.data));
            check("out_idx", 64'(out_idx), 64'(e.idx));
            check("out_beat", 64'(out_beat), 64'(e.beat));
            check("out_none", 64'(out_none), 64'(e.none));
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t  tbl [9];
    beat_t b;
    logic  ok;
    int    lat;

    tbl[0] = mkv(pack4(100, 50, 50, 200), 4'b1111, 1'b0, 1'b0, 1'b1, 50, 1, 0, 1'b0);
    tbl[1] = mkv(pack4(100, 50, 50, 200), 4'b1101, 1'b0, 1'b0, 1'b1, 50, 2, 0, 1'b0);
    tbl[2] = mkv(pack4(100, 50, 50, 200), 4'b0000, 1'b0, 1'b0, 1'b1, 19'h7FFFF, 0, 0, 1'b1);
    tbl[3] = mkv(pack4(9, 9, 9, 9), 4'b1111, 1'b0, 1'b0, 1'b1, 9, 0, 0, 1'b0);
    tbl[4] = mkv(pack4(1, 2, 3, 4), 4'b1000, 1'b0, 1'b0, 1'b1, 4, 3, 0, 1'b0);
    tbl[5] = mkv(pack4(19'h7FFFF, 19'h7FFFF, 19'h7FFFF, 19'h7FFFF), 4'b0100, 1'b0, 1'b0,
                 1'b1, 19'h7FFFF, 2, 0, 1'b0);
    tbl[6] = mkv(pack4(40, 90, 80, 30), 4'b1111, 1'b1, 1'b0, 1'b0, 0, 0, 0, 1'b0);
    tbl[7] = mkv(pack4(20, 25, 20, 70), 4'b1111, 1'b1, 1'b0, 1'b0, 0, 0, 0, 1'b0);
    tbl[8] = mkv(pack4(60, 21, 20, 20), 4'b1111, 1'b1, 1'b1, 1'b1, 20, 0, 1, 1'b0);

    // Reset held two edges with a valid beat presented.
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_data   = pack4(1, 2, 3, 4);
    in_mask   = '1;
    in_mode   = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_data", 64'(out_data), 64'd0);
      check("rst_out_idx", 64'(out_idx), 64'd0);
      check("rst_out_beat", 64'(out_beat), 64'd0);
      check("rst_out_none", 64'(out_none), 64'd0);
    end
    rst_n    = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("in_ready_after_reset", 64'(in_ready), 64'd1);
    check("out_valid_after_reset", 64'(out_valid), 64'd0);
    mon_en = 1'b1;
    @(posedge clk);
    #1;

    // Latency from an empty pipe.
    exp_q.push_back(tbl[0].exp);
    send(tbl[0].b, ok);
    lat = 0;
    while (lat < 10) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
    end
    check("latency", 64'(lat), 64'd3);
    @(posedge clk);
    #1;
    drain();

    // Directed vectors.
    for (int v = 0; v < 9; v++) begin
      if (tbl[v].exp_out) exp_q.push_back(tbl[v].exp);
      send(tbl[v].b, ok);
    end
    drain();

    // Reset in the middle of an accumulate burst discards it.
    b = '{data: pack4(5, 6, 3, 8), mask: 4'b1111, mode: 1'b1, last: 1'b0};
    send(b, ok);
    b.data = pack4(9, 4, 9, 9);
    send(b, ok);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    burst_q.delete();
    exp_q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("midburst_reset_no_out", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    exp_q.push_back('{data: 19'd7, idx: 2'd2, beat: 8'd0, none: 1'b0});
    b = '{data: pack4(50, 60, 7, 90), mask: 4'b1111, mode: 1'b1, last: 1'b1};
    send(b, ok);
    drain();

    // Backpressure: six per-beat results against a stalled sink.
    out_ready = 1'b0;
    saw_low   = 1'b0;
    fork
      begin
        for (int n = 0; n < 6; n++) send_model(rand_beat(1'b1));
      end
      begin
        repeat (5) begin
          @(negedge clk);
          if (!in_ready) saw_low = 1'b1;
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    check("in_ready_backpressure", 64'(saw_low), 64'd1);
    drain();

    // Randomized traffic with random sink stalls.
    done = 1'b0;
    fork
      begin
        for (int n = 0; n < 300; n++) send_model(rand_beat(1'b0));
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1 out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
